// File: rtl/ifetch_ctrl_pkg.sv
// Shared CPU definitions for the instruction fetch path: address width,
// pc increment, buffer entry layout and the fetch state encoding.
package ifetch_ctrl_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [ADDR_W-1:0] PC_STEP = 8'd4;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction delivery handshake between the fetch unit (master) and the
// decode stage (slave).
interface ifetch_ctrl_if;
    import ifetch_ctrl_pkg::*;

    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc;

    modport master (output inst_valid, output inst_out, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst_out, input inst_pc, output inst_ready);

endinterface

// File: rtl/ifetch_fifo.sv
// Two-entry instruction buffer holding {pc, word}; flush drops everything
// and an empty buffer reads as zero.
module ifetch_fifo
    import ifetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    output logic [ENTRY_W-1:0] rdata_o,
    output logic [1:0]         count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam logic [1:0] FULL_CNT = DEPTH[1:0];

    logic [ENTRY_W-1:0] mem_q [0:1];
    logic [ENTRY_W-1:0] mem_d [0:1];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic               do_push_s, do_pop_s;

    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == 2'd0);
    assign count_o   = count_q;
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = empty_o ? {ENTRY_W{1'b0}} : mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; flush overrides both ops.
    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= {ENTRY_W{1'b0}};
            mem_q[1] <= {ENTRY_W{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: owns the pc, the FETCH/DRAIN/HALTED FSM and
// the delivered-instruction counter; buffering lives in ifetch_fifo.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 8'h00,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    output logic              halted,
    output logic [15:0]       deliv_cnt,
    ifetch_ctrl_if.master     inst_if
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               push_s, pop_s, full_s, empty_s;
    logic [1:0]         fifo_cnt_s;
    logic [ENTRY_W-1:0] head_s;

    assign im_addr            = pc_q;
    assign halted             = (state_q == HALTED);
    assign deliv_cnt          = cnt_q;
    assign inst_if.inst_valid = !empty_s;
    assign inst_if.inst_out   = head_s[DATA_W-1:0];
    assign inst_if.inst_pc    = head_s[ENTRY_W-1:DATA_W];
    assign pop_s              = inst_if.inst_valid && inst_if.inst_ready;
    // halt_req suppresses the push in the cycle FETCH hands over to DRAIN.
    assign push_s = (state_q == FETCH) && !full_s && !redirect_valid && !halt_req;

    ifetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (redirect_valid),
        .wdata_i ({pc_q, im_data}),
        .rdata_o (head_s),
        .count_o (fifo_cnt_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // FSM next state, pc update and delivery count.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = pop_s ? (cnt_q + 16'd1) : cnt_q;
        if (redirect_valid) begin
            state_d = FETCH;
            pc_d    = align_pc(redirect_pc);
        end else begin
            case (state_q)
                FETCH: begin
                    if (halt_req) begin
                        state_d = DRAIN;
                    end else if (push_s) begin
                        pc_d = pc_q + PC_STEP;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                DRAIN: begin
                    // Halt as soon as the last buffered entry leaves.
                    if (empty_s || ((fifo_cnt_s == 2'd1) && pop_s)) begin
                        state_d = HALTED;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                HALTED: state_d = HALTED;
                default: state_d = FETCH;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= align_pc(RESET_PC);
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: first fetch address after reset; bits [1:0] ignored.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries; only the value 2 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port im_addr  output  8  byte address to the instruction memory; always word-aligned.
REQ-006 SHALL have port im_data  input  32  instruction word returned combinationally by memory in the same cycle.
REQ-007 SHALL have port redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-008 SHALL have port redirect_pc  input  8  new fetch address for a branch or jump.
REQ-009 SHALL have port halt_req  input  1  stop fetching and drain the buffer.
REQ-010 SHALL have port inst_valid  output  1  buffer head holds an instruction.
REQ-011 SHALL have port inst_ready  input  1  consumer accepts the head this cycle.
REQ-012 SHALL have port inst_out  output  32  instruction word at the buffer head.
REQ-013 SHALL have port inst_pc  output  8  address of inst_out.
REQ-014 SHALL have port halted  output  1  high in state HALTED.
REQ-015 SHALL have port deliv_cnt  output  16  count of accepted instructions.

Function
REQ-016 SHALL drive im_addr from the pc register at all times; memory is not gated.
REQ-017 SHALL push {pc, im_data} into the buffer and set pc to pc+4 in one cycle when state is FETCH, the buffer is not full, and redirect_valid=0.
REQ-018 SHALL wrap pc modulo 256: 8'hFC+4 gives 8'h00.
REQ-019 SHALL complete a handshake when inst_valid=1 and inst_ready=1; the head is popped and deliv_cnt incremented, wrapping FFFF to 0000.
REQ-020 SHALL allow push and pop in the same cycle; when full, a same-cycle pop does not enable a push (push is decided on the pre-pop count).
REQ-021 SHALL give the first pushed instruction a latency of 1 cycle: inst_valid rises on the cycle after the push.
REQ-022 SHALL, on redirect_valid=1, honour any head handshake that cycle, then flush all entries, set pc to {redirect_pc[7:2],2'b00}, push nothing, and enter FETCH from any state.
REQ-023 SHALL give redirect priority over halt_req when both are high in the same cycle; halt_req is then ignored.
REQ-024 SHALL use states FETCH, DRAIN and HALTED. FETCH goes to DRAIN on halt_req=1 with no push in that cycle. DRAIN goes to HALTED when the buffer becomes empty. HALTED is left only by redirect.
REQ-025 SHALL hold pc constant in DRAIN and HALTED.
REQ-026 SHALL hold inst_out and inst_pc stable while inst_valid=1 and inst_ready=0.

Reset
REQ-027 SHALL, with rst_n low, set pc=RESET_PC&8'hFC, state=FETCH, buffer empty, inst_valid=0, halted=0, deliv_cnt=0; inst_out and inst_pc read 0.
REQ-028 SHALL treat reset mid-operation as discarding all buffered entries; fetch resumes at RESET_PC on the first clock edge after rst_n rises.

Structure
REQ-029 SHALL take the state enum, PC_STEP=4 and ADDR_W=8 from the shared CPU package.
REQ-030 SHALL implement the buffer as one sub-module, ifetch_fifo: 2 entries of 40 bits, with push, pop, flush, full and empty; ifetch_ctrl holds the pc, FSM and counter.

Verification
REQ-031 SHALL cover: reset with inst_ready=1 -> im_addr 00,04,08 on successive cycles; inst_out 20100000 @pc00, then 20110000 @pc04, then 00009024 @pc08, one per cycle.
REQ-032 SHALL cover: inst_ready=0 for 5 cycles after reset -> buffer holds pc00 and pc04, im_addr stays 08; after release, deliveries are 00,04,08 in order.
REQ-033 SHALL cover: redirect_pc=8'h13 while full -> flush; next delivered 12280004 @pc10; deliv_cnt excludes flushed entries.
REQ-034 SHALL cover: redirect_pc=8'hFC -> delivers 00000000 @pcFC, then 20100000 @pc00.
REQ-035 SHALL cover: halt_req with 2 entries buffered -> 2 more deliveries, then halted=1 and im_addr frozen; redirect 8'h24 -> halted=0, next delivered ac120040 @pc24.
REQ-036 SHALL cover: redirect and halt_req in the same cycle -> state FETCH and halted stays 0.
